// File: rtl/dual_regfile_if.sv
// -----------------------------------------------------------------------------
// dual_regfile_if
//
// Purpose:
//   Groups the write-back-to-regfile bus, the four GPR read addresses and all
//   read data returned to decode into one bundle.
//
// Signals:
//   wb_to_rf_bus  : packed write-back bus, two slots.
//                   MSB->LSB {hilo_i2, we_i2, waddr_i2, wdata_i2,
//                             hilo_i1, we_i1, waddr_i1, wdata_i1}
//                   hilo_ix = {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}
//   raddr*_i*     : GPR read addresses, two per issue slot
//   rdata*_i*     : GPR read data, combinational
//   hi_rdata      : current HI value, bypassed
//   lo_rdata      : current LO value, bypassed
//
// Modports:
//   master : write-back / decode side, drives the bus and read addresses
//   slave  : register file side, returns read data
// -----------------------------------------------------------------------------
interface dual_regfile_if #(
    parameter int WB_TO_RF_WD = 208
);
    logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;

    logic [4:0]  raddr1_i1;
    logic [4:0]  raddr2_i1;
    logic [4:0]  raddr1_i2;
    logic [4:0]  raddr2_i2;

    logic [31:0] rdata1_i1;
    logic [31:0] rdata2_i1;
    logic [31:0] rdata1_i2;
    logic [31:0] rdata2_i2;

    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    modport master (
        output wb_to_rf_bus,
        output raddr1_i1, raddr2_i1, raddr1_i2, raddr2_i2,
        input  rdata1_i1, rdata2_i1, rdata1_i2, rdata2_i2,
        input  hi_rdata, lo_rdata
    );

    modport slave (
        input  wb_to_rf_bus,
        input  raddr1_i1, raddr2_i1, raddr1_i2, raddr2_i2,
        output rdata1_i1, rdata2_i1, rdata1_i2, rdata2_i2,
        output hi_rdata, lo_rdata
    );
endinterface

// File: rtl/dual_regfile.sv
// -----------------------------------------------------------------------------
// dual_regfile
//
// Purpose:
//   Architectural register file for the dual-issue pipeline. Holds r1..r31
//   plus HI and LO. Accepts two GPR writes and two HI/LO writes per cycle from
//   write-back and serves four GPR reads and one HI/LO read with write-through
//   bypass, so a value being written this cycle is already visible on the
//   read ports.
//
// Ports:
//   clk    : system clock, state updates on the rising edge
//   rst    : asynchronous active-high reset, clears all state
//   rf_if  : dual_regfile_if.slave bundle (write-back bus, read addresses,
//            read data, HI/LO read data)
//
// Ordering:
//   Slot i2 is younger than slot i1 in program order, so whenever both slots
//   target the same GPR or the same HI/LO half, i2's value wins, both for the
//   stored value and for the bypass.
// -----------------------------------------------------------------------------
module dual_regfile #(
    parameter int HILO_WD     = 66,
    parameter int WB_TO_RF_WD = 208
) (
    input  logic           clk,
    input  logic           rst,
    dual_regfile_if.slave  rf_if
);

    // Width of one write-back slot: {hilo, we, waddr, wdata}
    localparam int SLOT_WD = HILO_WD + 1 + 5 + 32;

    // -------------------------------------------------------------------------
    // Bus unpacking
    // -------------------------------------------------------------------------
    logic [SLOT_WD-1:0] slot_i1;
    logic [SLOT_WD-1:0] slot_i2;

    logic        we_i1,    we_i2;
    logic [4:0]  waddr_i1, waddr_i2;
    logic [31:0] wdata_i1, wdata_i2;

    logic        hi_we_i1, hi_we_i2;
    logic        lo_we_i1, lo_we_i2;
    logic [31:0] hi_wdata_i1, hi_wdata_i2;
    logic [31:0] lo_wdata_i1, lo_wdata_i2;

    assign slot_i1 = rf_if.wb_to_rf_bus[SLOT_WD-1:0];
    assign slot_i2 = rf_if.wb_to_rf_bus[WB_TO_RF_WD-1:SLOT_WD];

    // Split each slot into its GPR write fields and its HI/LO write fields.
    always_comb begin
        wdata_i1    = slot_i1[31:0];
        waddr_i1    = slot_i1[36:32];
        we_i1       = slot_i1[37];
        lo_wdata_i1 = slot_i1[69:38];
        hi_wdata_i1 = slot_i1[101:70];
        lo_we_i1    = slot_i1[102];
        hi_we_i1    = slot_i1[103];

        wdata_i2    = slot_i2[31:0];
        waddr_i2    = slot_i2[36:32];
        we_i2       = slot_i2[37];
        lo_wdata_i2 = slot_i2[69:38];
        hi_wdata_i2 = slot_i2[101:70];
        lo_we_i2    = slot_i2[102];
        hi_we_i2    = slot_i2[103];
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] rf_q [1:31];
    logic [31:0] rf_d [1:31];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Next GPR state. Writes to r0 fall outside the loop range and vanish.
    // i2 is checked first so that it overrides i1 on an address collision.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            rf_d[i] = rf_q[i];
            if (we_i2 && (waddr_i2 == 5'(i))) begin
                rf_d[i] = wdata_i2;
            end else if (we_i1 && (waddr_i1 == 5'(i))) begin
                rf_d[i] = wdata_i1;
            end
        end
    end

    // Next HI/LO state. Each half is independent, so an MTHI leaves LO alone
    // and an MTLO leaves HI alone.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we_i2) begin
            hi_d = hi_wdata_i2;
        end else if (hi_we_i1) begin
            hi_d = hi_wdata_i1;
        end
        if (lo_we_i2) begin
            lo_d = lo_wdata_i2;
        end else if (lo_we_i1) begin
            lo_d = lo_wdata_i1;
        end
    end

    // State registers. Reset holds everything at zero, which also blocks any
    // write presented while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------

    // Full 32-entry view of storage with r0 tied to zero, so every read port
    // can index it directly with its 5-bit address.
    logic [31:0] rf_view [0:31];

    always_comb begin
        rf_view[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            rf_view[i] = rf_q[i];
        end
    end

    // One GPR read port: r0 is hard zero, then the younger slot's write data,
    // then the older slot's, then storage. Bypass is suppressed during reset
    // so that the outputs read zero while rst is held.
    function automatic logic [31:0] gpr_read(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic        bypass_en,
        input logic        we_a,
        input logic [4:0]  waddr_a,
        input logic [31:0] wdata_a,
        input logic        we_b,
        input logic [4:0]  waddr_b,
        input logic [31:0] wdata_b
    );
        logic [31:0] value;
        value = stored;
        if (addr == 5'd0) begin
            value = 32'd0;
        end else if (bypass_en && we_b && (waddr_b == addr)) begin
            value = wdata_b;
        end else if (bypass_en && we_a && (waddr_a == addr)) begin
            value = wdata_a;
        end
        return value;
    endfunction

    logic bypass_en;
    assign bypass_en = ~rst;

    // The four GPR read ports share the same priority logic.
    always_comb begin
        rf_if.rdata1_i1 = gpr_read(rf_if.raddr1_i1, rf_view[rf_if.raddr1_i1],
                                   bypass_en, we_i1, waddr_i1, wdata_i1,
                                   we_i2, waddr_i2, wdata_i2);
        rf_if.rdata2_i1 = gpr_read(rf_if.raddr2_i1, rf_view[rf_if.raddr2_i1],
                                   bypass_en, we_i1, waddr_i1, wdata_i1,
                                   we_i2, waddr_i2, wdata_i2);
        rf_if.rdata1_i2 = gpr_read(rf_if.raddr1_i2, rf_view[rf_if.raddr1_i2],
                                   bypass_en, we_i1, waddr_i1, wdata_i1,
                                   we_i2, waddr_i2, wdata_i2);
        rf_if.rdata2_i2 = gpr_read(rf_if.raddr2_i2, rf_view[rf_if.raddr2_i2],
                                   bypass_en, we_i1, waddr_i1, wdata_i1,
                                   we_i2, waddr_i2, wdata_i2);
    end

    // HI/LO read follows the same younger-first priority per half, gated off
    // during reset like the GPR bypass.
    always_comb begin
        rf_if.hi_rdata = hi_q;
        rf_if.lo_rdata = lo_q;
        if (bypass_en && hi_we_i2) begin
            rf_if.hi_rdata = hi_wdata_i2;
        end else if (bypass_en && hi_we_i1) begin
            rf_if.hi_rdata = hi_wdata_i1;
        end
        if (bypass_en && lo_we_i2) begin
            rf_if.lo_rdata = lo_wdata_i2;
        end else if (bypass_en && lo_we_i1) begin
            rf_if.lo_rdata = lo_wdata_i1;
        end
    end

endmodule

// File: tb/tb_dual_regfile.sv
// -----------------------------------------------------------------------------
// tb_dual_regfile
//
// Directed bench for dual_regfile. Inputs are driven one time unit after the
// rising edge and the combinational outputs are sampled one unit later, so
// same-cycle bypass is observed before the edge that commits the write.
// -----------------------------------------------------------------------------
module tb_dual_regfile;

    logic clk;
    logic rst;

    int checks;
    int errors;

    dual_regfile_if #(.WB_TO_RF_WD(208)) rf_bus ();

    dual_regfile #(
        .HILO_WD     (66),
        .WB_TO_RF_WD (208)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rf_if (rf_bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds one write-back slot {hi_we, lo_we, hi, lo, we, waddr, wdata}.
    function automatic logic [103:0] slot(
        input logic        hi_we,
        input logic        lo_we,
        input logic [31:0] hi,
        input logic [31:0] lo,
        input logic        we,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        return {hi_we, lo_we, hi, lo, we, waddr, wdata};
    endfunction

    // Drives both bus slots and all four read addresses, then lets the
    // combinational read path settle.
    task automatic applyStimulus(
        input logic [103:0] s2,
        input logic [103:0] s1,
        input logic [4:0]   a1_i1,
        input logic [4:0]   a2_i1,
        input logic [4:0]   a1_i2,
        input logic [4:0]   a2_i2
    );
        rf_bus.wb_to_rf_bus = {s2, s1};
        rf_bus.raddr1_i1    = a1_i1;
        rf_bus.raddr2_i1    = a2_i1;
        rf_bus.raddr1_i2    = a1_i2;
        rf_bus.raddr2_i2    = a2_i2;
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] actual,
        input logic [31:0] expected
    );
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [103:0] IDLE = 104'd0;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // ---- Reset state --------------------------------------------------
        applyStimulus(IDLE, IDLE, 5'd1, 5'd5, 5'd31, 5'd0);
        checkOutput("reset_rd1_i1", rf_bus.rdata1_i1, 32'd0);
        checkOutput("reset_rd2_i1", rf_bus.rdata2_i1, 32'd0);
        checkOutput("reset_rd1_i2", rf_bus.rdata1_i2, 32'd0);
        checkOutput("reset_hi", rf_bus.hi_rdata, 32'd0);
        checkOutput("reset_lo", rf_bus.lo_rdata, 32'd0);

        // Write presented during reset: no bypass, no store.
        applyStimulus(IDLE, slot(1'b1, 1'b1, 32'h77, 32'h88, 1'b1, 5'd9, 32'h0000ABCD),
                      5'd9, 5'd9, 5'd9, 5'd9);
        checkOutput("rst_no_bypass_gpr", rf_bus.rdata1_i1, 32'd0);
        checkOutput("rst_no_bypass_hi", rf_bus.hi_rdata, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(IDLE, IDLE, 5'd9, 5'd9, 5'd9, 5'd9);
        checkOutput("rst_no_store_gpr", rf_bus.rdata1_i1, 32'd0);
        checkOutput("rst_no_store_lo", rf_bus.lo_rdata, 32'd0);

        // ---- Mid-cycle asynchronous reset --------------------------------
        applyStimulus(IDLE, slot(1'b1, 1'b1, 32'h55, 32'h66, 1'b1, 5'd5, 32'h00001234),
                      5'd5, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(IDLE, IDLE, 5'd5, 5'd0, 5'd0, 5'd0);
        checkOutput("pre_rst_r5", rf_bus.rdata1_i1, 32'h00001234);
        checkOutput("pre_rst_hi", rf_bus.hi_rdata, 32'h55);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_r5", rf_bus.rdata1_i1, 32'd0);
        checkOutput("async_rst_hi", rf_bus.hi_rdata, 32'd0);
        checkOutput("async_rst_lo", rf_bus.lo_rdata, 32'd0);
        tick();
        rst = 1'b0;

        // ---- Single write with bypass ------------------------------------
        applyStimulus(IDLE, slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF),
                      5'd3, 5'd4, 5'd0, 5'd0);
        checkOutput("single_bypass", rf_bus.rdata1_i1, 32'hDEADBEEF);
        checkOutput("single_other_reg", rf_bus.rdata2_i1, 32'd0);
        tick();
        applyStimulus(IDLE, IDLE, 5'd3, 5'd0, 5'd0, 5'd0);
        checkOutput("single_stored", rf_bus.rdata1_i1, 32'hDEADBEEF);

        // ---- Both slots hit r7, i2 wins ----------------------------------
        applyStimulus(slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h22222222),
                      slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h11111111),
                      5'd7, 5'd7, 5'd7, 5'd7);
        checkOutput("coll_byp_rd1_i1", rf_bus.rdata1_i1, 32'h22222222);
        checkOutput("coll_byp_rd2_i1", rf_bus.rdata2_i1, 32'h22222222);
        checkOutput("coll_byp_rd1_i2", rf_bus.rdata1_i2, 32'h22222222);
        checkOutput("coll_byp_rd2_i2", rf_bus.rdata2_i2, 32'h22222222);
        tick();
        applyStimulus(IDLE, IDLE, 5'd7, 5'd7, 5'd7, 5'd7);
        checkOutput("coll_st_rd1_i1", rf_bus.rdata1_i1, 32'h22222222);
        checkOutput("coll_st_rd2_i1", rf_bus.rdata2_i1, 32'h22222222);
        checkOutput("coll_st_rd1_i2", rf_bus.rdata1_i2, 32'h22222222);
        checkOutput("coll_st_rd2_i2", rf_bus.rdata2_i2, 32'h22222222);

        // ---- r0 stays zero ------------------------------------------------
        applyStimulus(IDLE, slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF),
                      5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_same_cycle", rf_bus.rdata1_i1, 32'd0);
        checkOutput("r0_same_cycle_i2", rf_bus.rdata2_i2, 32'd0);
        tick();
        applyStimulus(IDLE, IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_next_cycle", rf_bus.rdata1_i1, 32'd0);

        // ---- HI/LO: independent halves from different slots --------------
        applyStimulus(slot(1'b0, 1'b1, 32'd0, 32'hB, 1'b0, 5'd0, 32'd0),
                      slot(1'b1, 1'b0, 32'hA, 32'd0, 1'b0, 5'd0, 32'd0),
                      5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("hilo1_byp_hi", rf_bus.hi_rdata, 32'hA);
        checkOutput("hilo1_byp_lo", rf_bus.lo_rdata, 32'hB);
        tick();

        // i1 writes both halves, i2 writes HI only: HI from i2, LO from i1.
        applyStimulus(slot(1'b1, 1'b0, 32'hE, 32'd0, 1'b0, 5'd0, 32'd0),
                      slot(1'b1, 1'b1, 32'hC, 32'hD, 1'b0, 5'd0, 32'd0),
                      5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("hilo2_byp_hi", rf_bus.hi_rdata, 32'hE);
        checkOutput("hilo2_byp_lo", rf_bus.lo_rdata, 32'hD);
        tick();
        applyStimulus(IDLE, IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("hilo2_st_hi", rf_bus.hi_rdata, 32'hE);
        checkOutput("hilo2_st_lo", rf_bus.lo_rdata, 32'hD);

        // MTLO through i1 alone must leave HI untouched.
        applyStimulus(IDLE, slot(1'b0, 1'b1, 32'h99, 32'h0F, 1'b0, 5'd0, 32'd0),
                      5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(IDLE, IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("mtlo_hi_kept", rf_bus.hi_rdata, 32'hE);
        checkOutput("mtlo_lo_new", rf_bus.lo_rdata, 32'h0F);

        // ---- Fill r1..r31 with their index, two per cycle ----------------
        for (int k = 0; k < 16; k++) begin
            logic [4:0] a_odd;
            logic [4:0] a_even;
            logic       even_we;
            a_odd   = 5'(2 * k + 1);
            a_even  = 5'((2 * k + 2) % 32);
            even_we = (2 * k + 2) <= 31;
            applyStimulus(slot(1'b0, 1'b0, 32'd0, 32'd0, even_we, a_even, 32'(2 * k + 2)),
                          slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, a_odd, 32'(2 * k + 1)),
                          5'd0, 5'd0, 5'd0, 5'd0);
            tick();
        end

        // Three bubble cycles must change nothing.
        for (int b = 0; b < 3; b++) begin
            applyStimulus(IDLE, IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
            tick();
        end

        for (int r = 1; r < 32; r++) begin
            applyStimulus(IDLE, IDLE, 5'(r), 5'(32 - r), 5'(r), 5'(r));
            checkOutput($sformatf("fill_r%0d_rd1_i1", r), rf_bus.rdata1_i1, 32'(r));
            checkOutput($sformatf("fill_r%0d_rd2_i1", r), rf_bus.rdata2_i1, 32'(32 - r));
            checkOutput($sformatf("fill_r%0d_rd2_i2", r), rf_bus.rdata2_i2, 32'(r));
        end
        checkOutput("bubble_hi", rf_bus.hi_rdata, 32'hE);
        checkOutput("bubble_lo", rf_bus.lo_rdata, 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 20000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/dual_regfile.md
Name: dual_regfile

Overview:
- Architectural register file for the dual-issue pipeline, directly downstream of the write-back stage.
- Consumes the write-back-to-regfile bus: two GPR write slots plus two HI/LO write slots per cycle.
- Serves four GPR read ports (two per issue slot) and one HI/LO read to the decode stage.
- Provides write-through bypass so a value written in cycle N is visible to reads in the same cycle N.

Parameters:
- HILO_WD, 66, per-slot HI/LO bus width, packed {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}.
- WB_TO_RF_WD, 208, total bus width, 2*(HILO_WD+1+5+32).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_to_rf_bus  in  WB_TO_RF_WD  packing MSB->LSB: {hilo_i2, we_i2, waddr_i2[4:0], wdata_i2[31:0], hilo_i1, we_i1, waddr_i1[4:0], wdata_i1[31:0]}.
- raddr1_i1, raddr2_i1, raddr1_i2, raddr2_i2  in  5 each  GPR read addresses, slot1/slot2.
- rdata1_i1, rdata2_i1, rdata1_i2, rdata2_i2  out  32 each  GPR read data, combinational.
- hi_rdata  out  32  current HI, bypassed.
- lo_rdata  out  32  current LO, bypassed.

Behaviour:
- Storage: 31 x 32-bit GPRs (r1..r31), one 32-bit HI, one 32-bit LO. r0 is not stored.
- Reset: rst high asynchronously clears r1..r31, HI and LO to 0. Writes are ignored while rst is high. After reset all read outputs are 0.
- GPR write at posedge clk:
  - Slot i1 writes wdata_i1 to waddr_i1 when we_i1=1 and waddr_i1!=0.
  - Slot i2 writes under the same conditions.
  - Same address with both we=1: slot i2 value is stored, because i2 is younger in program order.
- HI/LO write at posedge clk, independent per half:
  - hi_we of either slot writes HI; lo_we of either slot writes LO.
  - Both slots writing the same half: i2 wins.
  - hi_we=1, lo_we=0 (MTHI) leaves LO unchanged; the converse applies for MTLO.
- GPR read, purely combinational, zero latency, priority per port:
  1. addr==0 -> 0, regardless of any write to r0.
  2. we_i2 && waddr_i2==addr -> wdata_i2.
  3. we_i1 && waddr_i1==addr -> wdata_i1.
  4. Stored register.
- HI/LO read uses the same priority per half: i2 write data, else i1 write data, else stored value.
- An all-zero bus (WB bubble after a stall or flush) causes no writes and no bypass.
- No stall or flush inputs: the upstream stage already zeroes bubbles.
- Reset asserted mid-cycle clears state immediately; read outputs reflect 0 except bypass terms. Bypass is gated off while rst=1, so outputs read 0.
- No registered outputs; the only sequential state is the register array plus HI/LO.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing r5=0x1234 -> rdata for r5 reads 0 immediately, HI=LO=0.
- Single write: we_i1=1, waddr_i1=3, wdata_i1=0xDEADBEEF.
  - Same cycle: raddr1_i1=3 returns 0xDEADBEEF via bypass.
  - Next cycle, bus idle: still 0xDEADBEEF from storage.
- Collision: both slots write r7 (i1=0x11111111, i2=0x22222222) -> bypass and stored value are both 0x22222222; all four read ports addressing r7 agree.
- r0: we_i1=1, waddr_i1=0, wdata_i1=0xFFFFFFFF -> r0 reads 0 in the same and following cycles.
- HI/LO:
  - i1 writes hi_we=1, hi=0xA; i2 writes lo_we=1, lo=0xB in the same cycle -> HI=0xA, LO=0xB.
  - Next cycle, i1 writes hi_we=lo_we=1 with 0xC/0xD and i2 writes hi_we=1 with 0xE -> HI=0xE, LO=0xD.
- Bubble: all-zero bus for 3 cycles after writing r1..r31 with their indices -> every register still reads its index, and HI/LO are unchanged.
